// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int          IFU_ADDR_W       = 32;
  localparam int          IFU_DATA_W       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    KILL
  } fetch_state_e;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch buffer: registered head, push visible at the head one cycle later.
// Push is dropped when full unless a pop frees the slot in the same cycle; flush empties it.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [W-1:0]             head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem read at a time, buffers {pc, instr} for decode.
// Acked data reaches decode one cycle later; fetch stalls in IDLE while the buffer is full.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                DATA_W   = IFU_DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i
);

  localparam int EW = ADDR_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              ack_fire, push, pop_fire;
  logic              fifo_full, fifo_empty, room_after_push;
  logic [CW-1:0]     fifo_cnt;
  logic [EW-1:0]     head;

  // KILL keeps presenting the address of the abandoned transfer until it completes
  assign imem_req_o   = (state_q == FETCH) || (state_q == KILL);
  assign imem_addr_o  = (state_q == KILL) ? kill_addr_q : fetch_pc_q;
  assign ack_fire     = imem_req_o && imem_ack_i;
  assign redirect_tgt = redirect_pc_i & ~ADDR_W'(3);

  assign instr_valid_o          = !fifo_empty;
  assign pop_fire               = instr_valid_o && instr_ready_i && !redirect_i;
  assign {instr_pc_o, instr_o}  = head;
  assign room_after_push        = (int'(fifo_cnt) + (pop_fire ? 0 : 1)) < DEPTH;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_addr_d = kill_addr_q;
    push        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_full) state_d = FETCH;
      end
      FETCH: begin
        if (ack_fire) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
          state_d    = room_after_push ? FETCH : IDLE;
        end
      end
      KILL: begin
        if (ack_fire) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_i) begin
      push       = 1'b0;
      fetch_pc_d = redirect_tgt;
      if (state_q == FETCH && !ack_fire) begin
        state_d     = KILL;
        kill_addr_d = fetch_pc_q;
      end else if (state_q == KILL && !ack_fire) begin
        state_d = KILL;
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      kill_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_addr_q <= kill_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redirect_i),
    .push_i     (push),
    .push_dat_i ({fetch_pc_q, imem_rdata_i}),
    .pop_i      (pop_fire),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt),
    .head_o     (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench with a scoreboard of expected {pc, instr} entries popped by a decoupled monitor.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, imem_req_o, imem_ack_i, redirect_i;
  logic        instr_valid_o, instr_ready_i;
  logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i, instr_o, instr_pc_o;

  fetch_entry_t exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           drop_pending = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata_i = instr_of(imem_addr_o);

  instr_fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Record the transfer completing at the coming edge, then advance one cycle.
  task automatic cyc();
    if (!rst_i) begin
      exp_q.delete();
      drop_pending = 1'b0;
    end else if (imem_req_o && imem_ack_i) begin
      if (drop_pending) drop_pending = 1'b0;
      else if (!redirect_i) exp_q.push_back('{pc: imem_addr_o, instr: instr_of(imem_addr_o)});
    end
    if (redirect_i) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench one cycle after reset release: first request is up at RESET_PC.
  task automatic do_reset();
    rst_i = 1'b0; imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    cyc(); cyc();
    rst_i = 1'b1;
    cyc();
  endtask

  task automatic drain(input string nm);
    imem_ack_i = 1'b0; instr_ready_i = 1'b1; redirect_i = 1'b0;
    repeat (3) cyc();
    chk({nm, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_i && instr_valid_o && instr_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_instr: got pc %h instr %h, required no entry", instr_pc_o, instr_o);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        chk("head_pc", instr_pc_o, e.pc);
        chk("head_instr", instr_o, e.instr);
      end
    end
  end

  initial begin
    rst_i = 1'b0; imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);

    // Streaming: zero-wait ack, decode always ready
    rst_i = 1'b1;
    cyc();
    imem_ack_i = 1'b1; instr_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t1_req", imem_req_o, 1);
      chk("t1_addr", imem_addr_o, 32'(4 * k));
      chk("t1_valid", instr_valid_o, (k > 0) ? 1 : 0);
      cyc();
    end
    drain("t1");

    // Backpressure fills the buffer, fetch stalls, restarts at PC 8 after pops
    do_reset();
    imem_ack_i = 1'b1; instr_ready_i = 1'b0;
    cyc();
    chk("t2_addr1", imem_addr_o, 32'h4);
    cyc();
    chk("t2_req_stall", imem_req_o, 0);
    chk("t2_valid_held", instr_valid_o, 1);
    chk("t2_pc_held", instr_pc_o, 32'h0);
    cyc();
    chk("t2_req_stall2", imem_req_o, 0);
    chk("t2_pc_held2", instr_pc_o, 32'h0);
    imem_ack_i = 1'b0; instr_ready_i = 1'b1;
    for (int i = 0; i < 5 && !imem_req_o; i++) cyc();
    chk("t2_req_resume", imem_req_o, 1);
    chk("t2_addr_resume", imem_addr_o, 32'h8);
    drain("t2");

    // Redirect during a waited transfer: address held, stale data dropped
    do_reset();
    imem_ack_i = 1'b1; instr_ready_i = 1'b1;
    cyc();
    imem_ack_i = 1'b0;
    chk("t3_addr_w1", imem_addr_o, 32'h4);
    cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    chk("t3_addr_w2", imem_addr_o, 32'h4);
    cyc();
    redirect_i = 1'b0;
    chk("t3_req_kill", imem_req_o, 1);
    chk("t3_addr_kill", imem_addr_o, 32'h4);
    cyc();
    imem_ack_i = 1'b1; drop_pending = 1'b1;
    chk("t3_addr_kill_ack", imem_addr_o, 32'h4);
    cyc();
    imem_ack_i = 1'b0;
    chk("t3_req_target", imem_req_o, 1);
    chk("t3_addr_target", imem_addr_o, 32'h100);
    chk("t3_valid_none", instr_valid_o, 0);
    drain("t3");

    // Redirect with a full buffer flushes it; target low bits cleared
    do_reset();
    imem_ack_i = 1'b1; instr_ready_i = 1'b0;
    cyc(); cyc();
    chk("t4_valid_before", instr_valid_o, 1);
    imem_ack_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h203;
    cyc();
    redirect_i = 1'b0;
    chk("t4_valid_flushed", instr_valid_o, 0);
    chk("t4_req", imem_req_o, 1);
    chk("t4_addr", imem_addr_o, 32'h200);
    drain("t4");

    // PC wrap at the top of the address space
    do_reset();
    imem_ack_i = 1'b1; instr_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cyc();
    redirect_i = 1'b0;
    chk("t5_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    cyc();
    chk("t5_out_pc", instr_pc_o, 32'hFFFF_FFFC);
    chk("t5_addr_wrap", imem_addr_o, 32'h0);
    drain("t5");

    // Reset while a request is pending; ack during reset ignored
    do_reset();
    imem_ack_i = 1'b1; instr_ready_i = 1'b0;
    cyc();
    imem_ack_i = 1'b0;
    chk("t6_addr_pending", imem_addr_o, 32'h4);
    cyc();
    rst_i = 1'b0; imem_ack_i = 1'b1;
    cyc();
    chk("t6_req_rst", imem_req_o, 0);
    chk("t6_valid_rst", instr_valid_o, 0);
    chk("t6_addr_rst", imem_addr_o, 32'h0);
    rst_i = 1'b1; imem_ack_i = 1'b0;
    cyc();
    chk("t6_req_first", imem_req_o, 1);
    chk("t6_addr_first", imem_addr_o, 32'h0);
    chk("t6_valid_first", instr_valid_o, 0);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
